// File: rtl/wb_write_arbiter_if.sv
// Write-back port bundle for wb_write_arbiter: ALU/LSU producers, regfile write port,
// pending-write query and FIFO occupancy. The master modport is the arbiter's view.
interface wb_write_arbiter_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            lsu_valid;
    logic            lsu_ready;
    logic [4:0]      lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic            alu_stall;
    logic            rf_we;
    logic [4:0]      rf_rd;
    logic [XLEN-1:0] rf_wdata;
    logic [4:0]      chk_rs1;
    logic [4:0]      chk_rs2;
    logic            chk_hit;
    logic [CW-1:0]   q_count;

    modport master (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  chk_rs1, chk_rs2,
        output lsu_ready, alu_stall,
        output rf_we, rf_rd, rf_wdata,
        output chk_hit, q_count
    );

    modport slave (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output chk_rs1, chk_rs2,
        input  lsu_ready, alu_stall,
        input  rf_we, rf_rd, rf_wdata,
        input  chk_hit, q_count
    );
endinterface

// File: rtl/wb_write_arbiter.sv
// Regfile write-port arbiter: ALU results win, loads queue in a small FIFO with anti-starvation stall.
// Optional macro WB_PENDING_CHECK_EN enables the chk_hit pending-write comparators.
module wb_write_arbiter #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    wb_write_arbiter_if.master wb
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]      q_rd_mem   [DEPTH];
    logic [XLEN-1:0] q_data_mem [DEPTH];

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            stall_q, stall_d;
    logic            rf_we_q, rf_we_d;
    logic [4:0]      rf_rd_q, rf_rd_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

    logic            lsu_ready;
    logic            lsu_acc;
    logic            alu_win;
    logic            fifo_ne;
    logic            enq;
    logic            deq;
    logic            sel_valid;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;

    always_comb begin
        lsu_ready = (count_q != CW'(DEPTH));
        lsu_acc   = wb.lsu_valid && lsu_ready;
        alu_win   = wb.alu_valid && !stall_q;
        fifo_ne   = (count_q != '0);

        sel_valid = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        enq       = 1'b0;
        deq       = 1'b0;

        if (alu_win) begin
            sel_valid = 1'b1;
            sel_rd    = wb.alu_rd;
            sel_data  = wb.alu_data;
            enq       = lsu_acc;
        end else if (fifo_ne) begin
            sel_valid = 1'b1;
            sel_rd    = q_rd_mem[rd_ptr_q];
            sel_data  = q_data_mem[rd_ptr_q];
            deq       = 1'b1;
            enq       = lsu_acc;
        end else if (lsu_acc) begin
            // Empty FIFO: the load goes straight to the output stage and is never stored.
            sel_valid = 1'b1;
            sel_rd    = wb.lsu_rd;
            sel_data  = wb.lsu_data;
        end
    end

    always_comb begin
        wr_ptr_d = enq ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = deq ? rd_ptr_q + PW'(1) : rd_ptr_q;

        count_d = count_q;
        if (enq && !deq) begin
            count_d = count_q + CW'(1);
        end else if (deq && !enq) begin
            count_d = count_q - CW'(1);
        end

        // Reaching the limit raises the stall for one cycle and restarts the count.
        starve_d = '0;
        stall_d  = 1'b0;
        if (fifo_ne && alu_win) begin
            if (starve_q == SW'(STARVE_LIMIT - 1)) begin
                stall_d = 1'b1;
            end else begin
                starve_d = starve_q + SW'(1);
            end
        end

        rf_we_d    = sel_valid && (sel_rd != 5'd0);
        rf_rd_d    = rf_we_d ? sel_rd   : rf_rd_q;
        rf_wdata_d = rf_we_d ? sel_data : rf_wdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            stall_q    <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_wdata_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            stall_q    <= stall_d;
            rf_we_q    <= rf_we_d;
            rf_rd_q    <= rf_rd_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    // Storage needs no reset: occupancy is governed entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_rd_mem[wr_ptr_q]   <= wb.lsu_rd;
            q_data_mem[wr_ptr_q] <= wb.lsu_data;
        end
    end

    assign wb.lsu_ready = lsu_ready;
    assign wb.alu_stall = stall_q;
    assign wb.rf_we     = rf_we_q;
    assign wb.rf_rd     = rf_rd_q;
    assign wb.rf_wdata  = rf_wdata_q;
    assign wb.q_count   = count_q;

`ifdef WB_PENDING_CHECK_EN
    logic          hit;
    logic [PW-1:0] idx;

    always_comb begin
        hit = 1'b0;
        idx = '0;
        // Walk live entries by offset from the head so wrap-around needs no special case.
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PW'(k);
            if ((CW'(k) < count_q) && (q_rd_mem[idx] != 5'd0) &&
                ((q_rd_mem[idx] == wb.chk_rs1) || (q_rd_mem[idx] == wb.chk_rs2))) begin
                hit = 1'b1;
            end
        end
        if (rf_we_q && (rf_rd_q != 5'd0) &&
            ((rf_rd_q == wb.chk_rs1) || (rf_rd_q == wb.chk_rs2))) begin
            hit = 1'b1;
        end
    end

    assign wb.chk_hit = hit;
`else
    logic unused_chk;
    assign unused_chk = ^{wb.chk_rs1, wb.chk_rs2};
    assign wb.chk_hit = 1'b0;
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter: directed vector table, hand sequences for
// fill/starvation, pending-check and async reset, then random traffic against a queue model.
module tb_wb_write_arbiter;
    localparam int unsigned XLEN         = 32;
    localparam int unsigned DEPTH        = 2;
    localparam int unsigned STARVE_LIMIT = 4;
`ifdef WB_PENDING_CHECK_EN
    localparam bit PCHK = 1'b1;
`else
    localparam bit PCHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_write_arbiter_if #(.XLEN(XLEN), .DEPTH(DEPTH)) wbif ();

    wb_write_arbiter #(
        .XLEN(XLEN),
        .DEPTH(DEPTH),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wb(wbif)
    );

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldat;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic [1:0]  qc;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: load queue plus the registered write port and stall flag.
    ent_t        m_q[$];
    int          m_starve;
    bit          m_stall;
    bit          m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_wd;
    bit          m_acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_starve = 0;
        m_stall  = 1'b0;
        m_we     = 1'b0;
        m_rd     = '0;
        m_wd     = '0;
        m_acc    = 1'b0;
    endtask

    // One clock of the arbitration rules applied to the current inputs.
    task automatic model_step();
        ent_t e;
        bit   have;
        int   sz;
        bit   acc;
        e    = '0;
        sz   = m_q.size();
        acc  = wbif.lsu_valid && (sz != DEPTH);
        have = 1'b0;
        if (wbif.alu_valid && !m_stall) begin
            e    = '{wbif.alu_rd, wbif.alu_data};
            have = 1'b1;
            if (acc) m_q.push_back('{wbif.lsu_rd, wbif.lsu_data});
            m_starve = (sz > 0) ? m_starve + 1 : 0;
        end else if (sz > 0) begin
            e    = m_q.pop_front();
            have = 1'b1;
            if (acc) m_q.push_back('{wbif.lsu_rd, wbif.lsu_data});
            m_starve = 0;
        end else begin
            m_starve = 0;
            if (acc) begin
                e    = '{wbif.lsu_rd, wbif.lsu_data};
                have = 1'b1;
            end
        end
        m_stall = (m_starve == STARVE_LIMIT);
        if (m_stall) m_starve = 0;
        m_we = have && (e.rd != 5'd0);
        if (m_we) begin
            m_rd = e.rd;
            m_wd = e.data;
        end
        m_acc = acc;
    endtask

    function automatic bit model_hit();
        bit h;
        h = 1'b0;
        foreach (m_q[i]) begin
            if (m_q[i].rd != 5'd0 && (m_q[i].rd == wbif.chk_rs1 || m_q[i].rd == wbif.chk_rs2)) h = 1'b1;
        end
        if (m_we && m_rd != 5'd0 && (m_rd == wbif.chk_rs1 || m_rd == wbif.chk_rs2)) h = 1'b1;
        return PCHK && h;
    endfunction

    task automatic check_model();
        chk("rf_we", 32'(wbif.rf_we), 32'(m_we));
        if (m_we) begin
            chk("rf_rd", 32'(wbif.rf_rd), 32'(m_rd));
            chk("rf_wdata", wbif.rf_wdata, m_wd);
        end
        chk("alu_stall", 32'(wbif.alu_stall), 32'(m_stall));
        chk("lsu_ready", 32'(wbif.lsu_ready), 32'(m_q.size() != DEPTH));
        chk("q_count", 32'(wbif.q_count), 32'(m_q.size()));
        chk("chk_hit", 32'(wbif.chk_hit), 32'(model_hit()));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ldat);
        wbif.alu_valid = av;
        wbif.alu_rd    = ard;
        wbif.alu_data  = adat;
        wbif.lsu_valid = lv;
        wbif.lsu_rd    = lrd;
        wbif.lsu_data  = ldat;
    endtask

    vec_t        vt[9];
    logic [4:0]  order[$];
    logic [4:0]  loads[3];
    int          li;
    bit          p_valid;
    logic [4:0]  p_rd;
    logic [31:0] p_data;

    initial begin
        vt[0] = '{1, 5, 32'hDEADBEEF, 0, 0, 0,            1, 5, 32'hDEADBEEF, 0};
        vt[1] = '{0, 0, 0,            0, 0, 0,            0, 0, 0,            0};
        vt[2] = '{0, 0, 0,            1, 7, 32'h12345678, 1, 7, 32'h12345678, 0};
        vt[3] = '{1, 3, 32'h1,        1, 4, 32'h2,        1, 3, 32'h1,        1};
        vt[4] = '{0, 0, 0,            0, 0, 0,            1, 4, 32'h2,        0};
        vt[5] = '{0, 0, 0,            0, 0, 0,            0, 0, 0,            0};
        vt[6] = '{1, 0, 32'hFFFFFFFF, 0, 0, 0,            0, 0, 0,            0};
        vt[7] = '{1, 1, 32'hA,        1, 0, 32'h55,       1, 1, 32'hA,        1};
        vt[8] = '{0, 0, 0,            0, 0, 0,            0, 0, 0,            0};

        drive(0, 0, 0, 0, 0, 0);
        wbif.chk_rs1 = '0;
        wbif.chk_rs2 = '0;
        model_reset();

        // Reset state
        #22;
        chk("rst_rf_we", 32'(wbif.rf_we), 32'd0);
        chk("rst_rf_rd", 32'(wbif.rf_rd), 32'd0);
        chk("rst_rf_wdata", wbif.rf_wdata, 32'd0);
        chk("rst_alu_stall", 32'(wbif.alu_stall), 32'd0);
        chk("rst_q_count", 32'(wbif.q_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_lsu_ready", 32'(wbif.lsu_ready), 32'd1);
        chk("rst_chk_hit", 32'(wbif.chk_hit), 32'd0);

        // Directed vector table
        for (int i = 0; i < 9; i++) begin
            drive(vt[i].av, vt[i].ard, vt[i].adat, vt[i].lv, vt[i].lrd, vt[i].ldat);
            tick();
            chk($sformatf("vec%0d_we", i), 32'(wbif.rf_we), 32'(vt[i].we));
            if (vt[i].we) begin
                chk($sformatf("vec%0d_rd", i), 32'(wbif.rf_rd), 32'(vt[i].rd));
                chk($sformatf("vec%0d_wdata", i), wbif.rf_wdata, vt[i].wd);
            end
            chk($sformatf("vec%0d_qcount", i), 32'(wbif.q_count), 32'(vt[i].qc));
            check_model();
        end

        // Fill to full under continuous ALU traffic, starvation stall, load order
        loads[0] = 5'd8;
        loads[1] = 5'd9;
        loads[2] = 5'd10;
        li = 0;
        for (int c = 0; c < 12; c++) begin
            drive(c < 7, 5'(20 + c), 32'(c), li < 3,
                  (li < 3) ? loads[li] : 5'd0, 32'h100 + 32'(li));
            tick();
            if (m_acc) li++;
            if (wbif.rf_we && wbif.rf_rd >= 5'd8 && wbif.rf_rd <= 5'd10) order.push_back(wbif.rf_rd);
            check_model();
            if (c == 1) begin
                chk("fill_qcount_full", 32'(wbif.q_count), 32'd2);
                chk("fill_lsu_ready_low", 32'(wbif.lsu_ready), 32'd0);
            end
            if (c == 3) chk("fill_no_early_stall", 32'(wbif.alu_stall), 32'd0);
            if (c == 4) chk("fill_stall_high", 32'(wbif.alu_stall), 32'd1);
            if (c == 5) begin
                chk("fill_stall_one_cycle", 32'(wbif.alu_stall), 32'd0);
                chk("fill_first_load_rd", 32'(wbif.rf_rd), 32'd8);
                chk("fill_first_load_we", 32'(wbif.rf_we), 32'd1);
            end
        end
        chk("fill_order_len", 32'(order.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < order.size()) chk($sformatf("fill_order%0d", i), 32'(order[i]), 32'(loads[i]));
        end

        // Pending-write query
        wbif.chk_rs1 = 5'd12;
        wbif.chk_rs2 = 5'd0;
        drive(1, 1, 32'h11, 1, 12, 32'hC0C0);
        tick();
        check_model();
        chk("pend_queued_hit", 32'(wbif.chk_hit), 32'(PCHK));
        drive(1, 2, 32'h22, 0, 0, 0);
        tick();
        check_model();
        chk("pend_blocked_hit", 32'(wbif.chk_hit), 32'(PCHK));
        drive(0, 0, 0, 0, 0, 0);
        tick();
        check_model();
        chk("pend_outstage_hit", 32'(wbif.chk_hit), 32'(PCHK));
        chk("pend_write_rd", 32'(wbif.rf_rd), 32'd12);
        tick();
        check_model();
        chk("pend_done_hit", 32'(wbif.chk_hit), 32'd0);
        wbif.chk_rs1 = 5'd0;
        drive(1, 1, 32'h33, 1, 0, 32'h44);
        tick();
        check_model();
        chk("pend_x0_hit", 32'(wbif.chk_hit), 32'd0);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        check_model();

        // Async reset with two queued loads
        drive(1, 2, 32'h5, 1, 13, 32'hD);
        tick();
        drive(1, 3, 32'h6, 1, 14, 32'hE);
        tick();
        chk("arst_pre_qcount", 32'(wbif.q_count), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rf_we", 32'(wbif.rf_we), 32'd0);
        chk("arst_rf_rd", 32'(wbif.rf_rd), 32'd0);
        chk("arst_rf_wdata", wbif.rf_wdata, 32'd0);
        chk("arst_qcount", 32'(wbif.q_count), 32'd0);
        chk("arst_lsu_ready", 32'(wbif.lsu_ready), 32'd1);
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("arst_no_write", 32'(wbif.rf_we), 32'd0);
            check_model();
        end

        // Randomized traffic against the model
        p_valid = 1'b0;
        p_rd    = '0;
        p_data  = '0;
        for (int c = 0; c < 600; c++) begin
            if (!p_valid && $urandom_range(0, 99) < 55) begin
                p_valid = 1'b1;
                p_rd    = 5'($urandom_range(0, 15));
                p_data  = $urandom;
            end
            drive($urandom_range(0, 99) < 65, 5'($urandom_range(0, 15)), $urandom,
                  p_valid, p_rd, p_data);
            wbif.chk_rs1 = 5'($urandom_range(0, 15));
            wbif.chk_rs2 = 5'($urandom_range(0, 15));
            tick();
            if (m_acc) p_valid = 1'b0;
            check_model();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
